// File: rtl/axi_cdma_mem_responder.sv
// AXI4 slave scratch memory answering one CDMA burst at a time through a single FSM.
// Define AXI_MEM_RESP_WAITSTATE_EN to insert pseudo-random W/R wait states from an LFSR.
module axi_cdma_mem_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ID_WIDTH-1:0]     s_awid,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]              s_awlen,
    input  logic [1:0]              s_awburst,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [ID_WIDTH-1:0]     s_bid,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ID_WIDTH-1:0]     s_arid,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]              s_arlen,
    input  logic [1:0]              s_arburst,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [ID_WIDTH-1:0]     s_rid,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast,
    output logic                    s_rvalid,
    input  logic                    s_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_WORDS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t                  state, state_next;
    logic                    last_grant_read;
    logic [ID_WIDTH-1:0]     id_q;
    logic [7:0]              len_q;
    logic [1:0]              burst_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [7:0]              beat_q;
    logic [1:0]              err_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              rresp_q;
    logic                    rlast_q;

    logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

    logic                    grant_w, aw_hs, ar_hs, w_hs, r_hs;
    logic                    burst_ok, w_inrange, w_en;
    logic [ADDR_WIDTH-1:0]   aw_idx, ar_idx, next_idx, rd_idx;
    logic                    rd_ok, rd_inrange;
    logic [DATA_WIDTH-1:0]   rd_word, rd_data;
    logic [1:0]              rd_resp, beat_err, err_acc;
    logic                    wready_base, rvalid_base;

    // Arbitration: a lone request always wins; on a conflict the side not served last wins.
    assign grant_w   = !s_arvalid || (s_awvalid && last_grant_read);
    assign aw_hs     = (state == IDLE) && s_awvalid && grant_w;
    assign ar_hs     = (state == IDLE) && s_arvalid && !grant_w;
    assign s_awready = aw_hs;
    assign s_arready = ar_hs;

    assign aw_idx    = (s_awaddr - BASE_ADDR) >> BYTE_SHIFT;
    assign ar_idx    = (s_araddr - BASE_ADDR) >> BYTE_SHIFT;
    assign burst_ok  = (burst_q == BURST_FIXED) || (burst_q == BURST_INCR);
    assign next_idx  = (burst_q == BURST_INCR) ? idx_q + ADDR_WIDTH'(1) : idx_q;

    // Read port serves beat 0 during the AR handshake and the following beat otherwise.
    assign rd_idx     = (state == IDLE) ? ar_idx : next_idx;
    assign rd_ok      = (state == IDLE) ? ((s_arburst == BURST_FIXED) || (s_arburst == BURST_INCR))
                                        : burst_ok;
    assign rd_inrange = rd_idx < MEM_LIMIT;
    assign rd_word    = mem[rd_idx[IDX_WIDTH-1:0]];
    assign rd_resp    = !rd_ok ? RESP_SLVERR : (!rd_inrange ? RESP_DECERR : RESP_OKAY);
    assign rd_data    = (rd_ok && rd_inrange) ? rd_word : '0;

    assign w_inrange  = idx_q < MEM_LIMIT;
    assign w_hs       = s_wvalid && s_wready;
    assign w_en       = w_hs && burst_ok && w_inrange;
    assign beat_err   = !burst_ok ? RESP_SLVERR : (!w_inrange ? RESP_DECERR : RESP_OKAY);

    // Sticky burst error; DECERR dominates SLVERR, and a wlast on the wrong beat is SLVERR.
    always_comb begin
        err_acc = RESP_OKAY;
        if (err_q == RESP_DECERR || beat_err == RESP_DECERR)
            err_acc = RESP_DECERR;
        else if (err_q == RESP_SLVERR || beat_err == RESP_SLVERR || (s_wlast && beat_q != len_q))
            err_acc = RESP_SLVERR;
    end

    assign wready_base = (state == WDATA);
    assign rvalid_base = (state == RDATA);

`ifdef AXI_MEM_RESP_WAITSTATE_EN
    logic [7:0] lfsr;
    logic       rvalid_hold;
    logic       stall;

    assign stall = (lfsr[1:0] == 2'b00);

    // Once presented, an R beat stays valid until taken even if the LFSR asks for a stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr        <= 8'hA5;
            rvalid_hold <= 1'b0;
        end else begin
            lfsr        <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            rvalid_hold <= s_rvalid && !s_rready;
        end
    end

    assign s_wready = wready_base && !stall;
    assign s_rvalid = rvalid_base && (rvalid_hold || !stall);
`else
    assign s_wready = wready_base;
    assign s_rvalid = rvalid_base;
`endif

    assign r_hs     = s_rvalid && s_rready;
    assign s_bvalid = (state == WRESP);
    assign s_bresp  = err_q;
    assign s_bid    = id_q;
    assign s_rid    = id_q;
    assign s_rdata  = rdata_q;
    assign s_rresp  = rresp_q;
    assign s_rlast  = rlast_q && (state == RDATA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (aw_hs)
                    state_next = WDATA;
                else if (ar_hs)
                    state_next = RDATA;
            end
            WDATA: if (w_hs && s_wlast) state_next = WRESP;
            WRESP: if (s_bready) state_next = IDLE;
            RDATA: if (r_hs && rlast_q) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_read <= 1'b1;
            id_q            <= '0;
            len_q           <= '0;
            burst_q         <= '0;
            idx_q           <= '0;
            beat_q          <= '0;
            err_q           <= RESP_OKAY;
            rdata_q         <= '0;
            rresp_q         <= RESP_OKAY;
            rlast_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        last_grant_read <= 1'b0;
                        id_q            <= s_awid;
                        len_q           <= s_awlen;
                        burst_q         <= s_awburst;
                        idx_q           <= aw_idx;
                        beat_q          <= '0;
                        err_q           <= RESP_OKAY;
                    end else if (ar_hs) begin
                        last_grant_read <= 1'b1;
                        id_q            <= s_arid;
                        len_q           <= s_arlen;
                        burst_q         <= s_arburst;
                        idx_q           <= ar_idx;
                        beat_q          <= '0;
                        rdata_q         <= rd_data;
                        rresp_q         <= rd_resp;
                        rlast_q         <= (s_arlen == 8'd0);
                    end
                end
                WDATA: begin
                    if (w_hs) begin
                        idx_q  <= next_idx;
                        beat_q <= beat_q + 8'd1;
                        err_q  <= err_acc;
                    end
                end
                RDATA: begin
                    if (r_hs && !rlast_q) begin
                        idx_q   <= next_idx;
                        beat_q  <= beat_q + 8'd1;
                        rdata_q <= rd_data;
                        rresp_q <= rd_resp;
                        rlast_q <= (beat_q + 8'd1 == len_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM has no reset so contents survive an abandoned burst.
    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_wstrb[b])
                    mem[idx_q[IDX_WIDTH-1:0]][b*8 +: 8] <= s_wdata[b*8 +: 8];
            end
        end
    end

endmodule
